// File: rtl/pc_stack.sv
// Program counter with inc/add/sub/load/call/ret operations and a small return-address stack.
// One operation per cycle (ret > call > load > sub > add > inc); sticky overflow/underflow flags.
module pc_stack #(
  parameter int          WIDTH     = 16,
  parameter int          DEPTH     = 4,
  parameter int          STEP      = 1,
  parameter int unsigned RESET_VEC = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,   // asynchronous, active-low
  input  logic                         inc_i,
  input  logic                         add_i,
  input  logic                         sub_i,
  input  logic                         load_i,
  input  logic                         call_i,
  input  logic                         ret_i,
  input  logic                         stall_i,
  input  logic                         clr_err_i,
  input  logic [WIDTH-1:0]             offset_i,
  input  logic [WIDTH-1:0]             target_i,
  output logic [WIDTH-1:0]             pc_o,
  output logic [$clog2(DEPTH+1)-1:0]   sp_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         ovf_o,
  output logic                         unf_o
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic             full, empty;
  logic             do_ret, do_call;
  logic             pop_ok, push_ok;
  logic             ovf_set, unf_set;
  logic [SPW-1:0]   sp_m1;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] pc_plus_step;

  assign full         = (sp_q == SPW'(DEPTH));
  assign empty        = (sp_q == '0);
  assign sp_m1        = sp_q - SPW'(1);
  assign wr_idx       = sp_q[AW-1:0];
  assign rd_idx       = empty ? '0 : sp_m1[AW-1:0];
  assign pc_plus_step = pc_q + WIDTH'(STEP);

  // ret outranks call, so a simultaneous call is dropped without raising ovf.
  assign do_ret  = ret_i && !stall_i;
  assign do_call = call_i && !ret_i && !stall_i;
  assign pop_ok  = do_ret && !empty;
  assign unf_set = do_ret && empty;
  assign push_ok = do_call && !full;
  assign ovf_set = do_call && full;

  always_comb begin
    pc_d = pc_q;
    sp_d = sp_q;
    if (!stall_i) begin
      if (ret_i) begin
        if (pop_ok) begin
          pc_d = stack_q[rd_idx];
          sp_d = sp_m1;
        end
      end else if (call_i) begin
        if (push_ok) begin
          pc_d = target_i;
          sp_d = sp_q + SPW'(1);
        end
      end else if (load_i) begin
        pc_d = target_i;
      end else if (sub_i) begin
        pc_d = pc_q - offset_i;
      end else if (add_i) begin
        pc_d = pc_q + offset_i;
      end else if (inc_i) begin
        pc_d = pc_plus_step;
      end
    end
  end

  // A same-cycle set beats clr_err; stall freezes the flags entirely.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (!stall_i) begin
      ovf_d = ovf_set || (ovf_q && !clr_err_i);
      unf_d = unf_set || (unf_q && !clr_err_i);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q  <= WIDTH'(RESET_VEC);
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage carries no reset; entries above sp are don't-care.
  always_ff @(posedge clk_i) begin
    if (push_ok && reset_ni) begin
      stack_q[wr_idx] <= pc_plus_step;
    end
  end

  assign pc_o    = pc_q;
  assign sp_o    = sp_q;
  assign full_o  = full;
  assign empty_o = empty;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed scenarios plus random strobes, checked by a scoreboard
// against a queue-based reference model of the program counter and return stack.
module tb_pc_stack;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int SPW   = 3;
  localparam int EW    = W + SPW + 4;

  localparam logic [7:0] R  = 8'h80;
  localparam logic [7:0] C  = 8'h40;
  localparam logic [7:0] L  = 8'h20;
  localparam logic [7:0] SU = 8'h10;
  localparam logic [7:0] A  = 8'h08;
  localparam logic [7:0] I  = 8'h04;
  localparam logic [7:0] ST = 8'h02;
  localparam logic [7:0] CE = 8'h01;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           inc = 0, add = 0, sub = 0, load = 0, call = 0, ret = 0, stall = 0, clr_err = 0;
  logic [W-1:0]   offset = '0, target = '0;
  logic [W-1:0]   pc;
  logic [SPW-1:0] sp;
  logic           full, empty, ovf, unf;

  int n_chk = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model
  logic [W-1:0] m_pc = '0;
  logic [W-1:0] m_stk[$];
  logic         m_ovf = 0, m_unf = 0;

  pc_stack #(.WIDTH(W), .DEPTH(DEPTH), .STEP(1), .RESET_VEC(0)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .inc_i(inc), .add_i(add), .sub_i(sub), .load_i(load),
    .call_i(call), .ret_i(ret), .stall_i(stall), .clr_err_i(clr_err),
    .offset_i(offset), .target_i(target),
    .pc_o(pc), .sp_o(sp), .full_o(full), .empty_o(empty), .ovf_o(ovf), .unf_o(unf)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  function automatic logic [EW-1:0] model_vec();
    int n = m_stk.size();
    return {m_pc, SPW'(n), (n == DEPTH), (n == 0), m_ovf, m_unf};
  endfunction

  function automatic void check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b, expected pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b",
               name, act[EW-1 -: W], act[3+SPW:4], act[3], act[2], act[1], act[0],
               expv[EW-1 -: W], expv[3+SPW:4], expv[3], expv[2], expv[1], expv[0]);
    end
  endfunction

  function automatic void model_step(input logic [7:0] s, input logic [W-1:0] off, input logic [W-1:0] tgt);
    logic set_o = 0, set_u = 0;
    if (s & ST) return;
    if (s & R) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else set_u = 1;
    end else if (s & C) begin
      if (m_stk.size() == DEPTH) set_o = 1;
      else begin
        m_stk.push_back(m_pc + W'(1));
        m_pc = tgt;
      end
    end else if (s & L)  m_pc = tgt;
    else if (s & SU)     m_pc = m_pc - off;
    else if (s & A)      m_pc = m_pc + off;
    else if (s & I)      m_pc = m_pc + W'(1);
    m_ovf = set_o | (m_ovf & !(s & CE));
    m_unf = set_u | (m_unf & !(s & CE));
  endfunction

  // Driver: apply strobes on the falling edge and queue the expected post-edge state
  task automatic drive(input logic [7:0] s, input logic [W-1:0] off = '0, input logic [W-1:0] tgt = '0);
    @(negedge clk);
    {ret, call, load, sub, add, inc, stall, clr_err} = s;
    offset = off;
    target = tgt;
    model_step(s, off, tgt);
    exp_q.push_back(model_vec());
  endtask

  // Reset dropped between edges, optionally while a call is being presented
  task automatic async_reset(input logic with_call);
    @(negedge clk);
    {ret, call, load, sub, add, inc, stall, clr_err} = with_call ? C : 8'h00;
    target = 16'h5555;
    #2 reset_n = 1'b0;
    m_pc = '0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
    #1 check("async_reset", {pc, sp, full, empty, ovf, unf}, model_vec());
    @(negedge clk);
    {ret, call, load, sub, add, inc, stall, clr_err} = 8'h00;
    reset_n = 1'b1;
  endtask

  // Monitor: every clock the DUT presents a new state; compare it against the queued expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("state", {pc, sp, full, empty, ovf, unf}, e);
    end
  end

  initial begin
    async_reset(1'b0);

    // inc x3 then add
    drive(I); drive(I); drive(I);
    drive(A, 16'h00A5);

    // sub wrap, inc wrap
    drive(L, '0, 16'h0005);
    drive(SU, 16'h0014);
    drive(L, '0, 16'hFFFF);
    drive(I);

    // fill stack, overflow, drain
    drive(L, '0, 16'h0010);
    repeat (5) drive(C, '0, 16'h0100);
    repeat (4) drive(R);
    drive(CE);

    // underflow, clear, clear racing a new underflow
    drive(R);
    drive(CE);
    drive(R | CE);
    drive(CE);

    // call+ret+inc with one entry; stall with inc
    drive(C, '0, 16'h0200);
    drive(R | C | I, '0, 16'h0300);
    drive(L, '0, 16'h4000);
    drive(ST | I | C, '0, 16'h0777);
    drive(R);
    drive(ST | CE | R);
    drive(CE);

    // async reset mid-call with sp=2, pc=0x1234
    drive(C, '0, 16'h0040);
    drive(C, '0, 16'h0080);
    drive(L, '0, 16'h1234);
    async_reset(1'b1);
    drive(I);

    // randomized strobes
    for (int n = 0; n < 400; n++) begin
      logic [7:0] s;
      s = 8'($urandom & $urandom);
      if ($urandom_range(0, 7) != 0) s = s & ~ST;
      if ($urandom_range(0, 3) != 0) s = s & ~CE;
      if ($urandom_range(0, 149) == 0) async_reset($urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 9) == 0) drive(L, '0, $urandom_range(16'hFFF0, 16'hFFFF));
      else drive(s, W'($urandom), W'($urandom));
    end

    @(negedge clk);
    {ret, call, load, sub, add, inc, stall, clr_err} = 8'h00;
    repeat (2) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 16, PC, offset and target width in bits.
REQ-002 Parameter DEPTH, default 4, return-stack entries (>=2).
REQ-003 Parameter STEP, default 1, increment applied by inc and pushed by call.
REQ-004 Parameter RESET_VEC, default 0, PC value after reset.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  asynchronous, active-low; 0 forces the reset state.
REQ-008 inc  input  1  PC <= PC + STEP.
REQ-009 add  input  1  PC <= PC + offset.
REQ-010 sub  input  1  PC <= PC - offset.
REQ-011 load  input  1  PC <= target.
REQ-012 call  input  1  push PC+STEP, then PC <= target.
REQ-013 ret  input  1  pop top of stack into PC.
REQ-014 stall  input  1  freeze all state for the cycle.
REQ-015 clr_err  input  1  clear sticky ovf/unf.
REQ-016 offset  input  WIDTH  unsigned operand for add/sub.
REQ-017 target  input  WIDTH  absolute address for load/call.
REQ-018 pc  output  WIDTH  current program counter, registered.
REQ-019 sp  output  clog2(DEPTH+1)  number of valid stack entries.
REQ-020 full  output  1  sp == DEPTH, combinational from sp.
REQ-021 empty  output  1  sp == 0, combinational from sp.
REQ-022 ovf  output  1  sticky, call attempted while full.
REQ-023 unf  output  1  sticky, ret attempted while empty.

Function
REQ-024 All state SHALL update only on the rising clk edge, except on reset assertion.
REQ-025 Per cycle at most one operation SHALL take effect; priority ret > call > load > sub > add > inc.
REQ-026 No strobe asserted SHALL hold pc and stack unchanged.
REQ-027 stall=1 SHALL hold pc, stack, sp, ovf and unf, overriding every strobe and clr_err.
REQ-028 pc arithmetic SHALL be modulo 2^WIDTH: wrap on overflow and underflow, no flag raised.
REQ-029 Result of an operation SHALL appear on pc one cycle after the sampling edge (latency 1).
REQ-030 call with sp<DEPTH SHALL write PC+STEP (mod 2^WIDTH) to entry sp, sp <= sp+1, pc <= target, in the same edge.
REQ-031 call with full=1 SHALL leave pc, stack and sp unchanged and set ovf.
REQ-032 ret with sp>0 SHALL set pc <= entry sp-1 and sp <= sp-1.
REQ-033 ret with empty=1 SHALL leave pc and sp unchanged and set unf.
REQ-034 call and ret in the same cycle SHALL execute ret only; call is dropped with no flag.
REQ-035 The stack SHALL be LIFO; popped entries are not cleared, and their contents are don't-care.
REQ-036 clr_err=1 SHALL clear ovf and unf; if a same-cycle event would set a flag, the set SHALL win.
REQ-037 Lower-priority strobes in a cycle SHALL have no side effect (no push, no flag).

Reset
REQ-038 reset=0 SHALL immediately, without clk, force pc=RESET_VEC, sp=0, ovf=0 and unf=0.
REQ-039 Stack RAM contents SHALL NOT require reset.
REQ-040 Reset asserted mid-call/ret SHALL discard the operation.
REQ-041 After reset release, the first operation SHALL be taken at the first rising edge with reset=1.

Verification (WIDTH=16, DEPTH=4, STEP=1, RESET_VEC=0)
REQ-042 Reset, then inc x3, then add offset=0x00A5 -> pc 0001, 0002, 0003, 00A8.
REQ-043 pc=0x0005, sub offset=0x0014 -> pc=0xFFF1; then inc from 0xFFFF -> 0x0000, with no flag.
REQ-044 From pc=0x0010, call target 0x0100 x4 -> sp=4, full=1; a 5th call -> pc holds 0x0100 and ovf=1; ret x4 -> pc 0101, 0101, 0101, 0011, and empty=1.
REQ-045 ret with empty=1 -> pc unchanged, unf=1; clr_err -> unf=0; clr_err together with another empty ret -> unf stays 1.
REQ-046 call+ret+inc together with sp=1 -> only the pop occurs and sp=0; stall=1 with inc -> all outputs unchanged.
REQ-047 Drop reset to 0 between edges with sp=2 and pc=0x1234 -> pc=0000, sp=0 and empty=1 before the next edge.
